// File: rtl/i2c_target_regif_if.sv
// Register-bus side of the I2C target: address, write strobe/data, read strobe/data.
interface i2c_target_regif_if #(
    parameter int unsigned ADDR_BYTES = 2
);
    logic [8*ADDR_BYTES-1:0] reg_addr;
    logic [7:0]              reg_wdata;
    logic                    reg_we;
    logic                    reg_re;
    logic [7:0]              reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_target_regif.sv
// I2C target with oversampled/filtered SCL+SDA, multi-byte register address,
// burst write and burst read with auto-increment over a simple register bus.
module i2c_target_regif #(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe,
    output logic busy,
    i2c_target_regif_if.master rbus
);
    localparam int unsigned AW = 8*ADDR_BYTES;

    typedef enum logic [3:0] {
        IDLE, DEVADDR, DEV_ACK, REGADDR, RA_ACK, WDATA, WD_ACK, RDATA, MACK, IGNORE
    } state_t;

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_f, sda_f;
    logic                scl_rise, scl_fall, sda_rise, sda_fall, start, stop;

    // Sync and filter state resets high to match an idle bus.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
            if (scl_rise)      scl_f <= 1'b1;
            else if (scl_fall) scl_f <= 1'b0;
            if (sda_rise)      sda_f <= 1'b1;
            else if (sda_fall) sda_f <= 1'b0;
        end
    end

    // Events are combinational so the FSM acts on the same edge the filtered level flips.
    always_comb begin
        scl_rise = (&scl_hist) & ~scl_f;
        scl_fall = ~(|scl_hist) & scl_f;
        sda_rise = (&sda_hist) & ~sda_f;
        sda_fall = ~(|sda_hist) & sda_f;
        start    = sda_fall & scl_f;
        stop     = sda_rise & scl_f;
    end

    state_t          state;
    logic [3:0]      bit_cnt;
    logic [1:0]      byte_cnt;
    logic [7:0]      shreg;
    logic [7:0]      rx_byte;
    logic [AW-1:0]   addr_stage;
    logic            rw;
    logic            rd_load;
    logic            mack_ok;

    assign rx_byte = {shreg[6:0], sda_f};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            shreg          <= '0;
            addr_stage     <= '0;
            rw             <= 1'b0;
            rd_load        <= 1'b0;
            mack_ok        <= 1'b0;
            sda_oe         <= 1'b0;
            busy           <= 1'b0;
            rbus.reg_addr  <= '0;
            rbus.reg_wdata <= '0;
            rbus.reg_we    <= 1'b0;
            rbus.reg_re    <= 1'b0;
        end else begin
            rbus.reg_we <= 1'b0;
            rbus.reg_re <= 1'b0;
            rd_load     <= rbus.reg_re;
            if (rbus.reg_we) rbus.reg_addr <= rbus.reg_addr + AW'(1);

            if (stop) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                rd_load <= 1'b0;
            end else if (start) begin
                state   <= DEVADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                rd_load <= 1'b0;
            end else begin
                case (state)
                    DEVADDR, REGADDR, WDATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (state == DEVADDR) begin
                                rw <= sda_f;
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state <= DEV_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == REGADDR) begin
                                addr_stage <= (addr_stage << 8) | AW'(rx_byte);
                                state      <= RA_ACK;
                            end else begin
                                rbus.reg_wdata <= rx_byte;
                                rbus.reg_we    <= 1'b1;
                                state          <= WD_ACK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // In ACK states sda_oe doubles as the phase flag: first fall drives, second releases.
                    DEV_ACK, RA_ACK, WD_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == DEV_ACK) begin
                                if (rw) begin
                                    rbus.reg_re <= 1'b1;
                                    state       <= RDATA;
                                end else begin
                                    byte_cnt <= '0;
                                    state    <= REGADDR;
                                end
                            end else if (state == RA_ACK) begin
                                if (byte_cnt == 2'(ADDR_BYTES-1)) begin
                                    rbus.reg_addr <= addr_stage;
                                    state         <= WDATA;
                                end else begin
                                    byte_cnt <= byte_cnt + 2'd1;
                                    state    <= REGADDR;
                                end
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (rd_load) begin
                            shreg  <= rbus.reg_rdata;
                            sda_oe <= ~rbus.reg_rdata[7];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                mack_ok <= 1'b0;
                                state   <= MACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                mack_ok       <= 1'b1;
                                rbus.reg_addr <= rbus.reg_addr + AW'(1);
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && mack_ok) begin
                            mack_ok     <= 1'b0;
                            rbus.reg_re <= 1'b1;
                            state       <= RDATA;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA, register model returning addr[7:0]^0x5A.
module tb_i2c_target_regif;
    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_oe, busy, sda_line;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regif_if #(.ADDR_BYTES(2)) rbus ();

    i2c_target_regif #(.DEV_ADDR(7'h3C), .ADDR_BYTES(2), .FILT_LEN(3)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .scl_i (scl),
        .sda_i (sda_line),
        .sda_oe(sda_oe),
        .busy  (busy),
        .rbus  (rbus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rbus.reg_re) rbus.reg_rdata <= rbus.reg_addr[7:0] ^ 8'h5A;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int re_cnt = 0;
    bit oe_seen = 0, busy_seen = 0;

    always @(negedge clk) begin
        if (rbus.reg_we) begin
            wa_q.push_back(rbus.reg_addr);
            wd_q.push_back(rbus.reg_wdata);
        end
        if (rbus.reg_re) re_cnt++;
        if (sda_oe) oe_seen = 1;
        if (busy) busy_seen = 1;
    end

    int checks = 0, errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa_at(input int i);
        return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        re_cnt = 0;
        oe_seen = 0;
        busy_seen = 0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq(Q);
        scl = 1'b1;   wq(Q);
        m_sda = 1'b0; wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wq(Q);
            scl = 1'b1;
            if (glitch && i == 7) begin
                wq(Q/2);
                m_sda = ~m_sda; wq(1);
                m_sda = ~m_sda; wq(Q - Q/2 - 1);
            end else begin
                wq(Q);
            end
            scl = 1'b0; wq(Q);
        end
        m_sda = 1'b1; wq(Q);
        scl = 1'b1; wq(Q/2);
        ack = ~sda_line;
        wq(Q - Q/2);
        scl = 1'b0; wq(Q);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1; wq(Q);
            scl = 1'b1; wq(Q/2);
            b = {b[6:0], sda_line};
            wq(Q - Q/2);
            scl = 1'b0; wq(Q);
        end
        m_sda = mack; wq(Q);
        scl = 1'b1;   wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic write_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input int n, output int acks);
        logic [7:0] bytes [5];
        logic a;
        bytes = '{b0, b1, b2, b3, b4};
        acks = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], 1'b0, a);
            if (a) acks++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int acks;
        logic a;
        logic [7:0] r0, r1;
        logic [7:0] bad_addr [2];
        bad_addr = '{8'h7A, 8'h00};

        wq(5);
        check_val("rst_sda_oe", 32'(sda_oe), 32'h0);
        check_val("rst_addr",   32'(rbus.reg_addr), 32'h0);
        check_val("rst_wdata",  32'(rbus.reg_wdata), 32'h0);
        check_val("rst_we",     32'(rbus.reg_we), 32'h0);
        check_val("rst_re",     32'(rbus.reg_re), 32'h0);
        check_val("rst_busy",   32'(busy), 32'h0);
        rst_n = 1'b1;
        wq(10);

        // single write
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'h30, 8'h08, 8'h82, 8'h00, 4, acks);
        check_val("sw_acks", 32'(acks), 32'd4);
        check_val("sw_busy_in", 32'(busy), 32'h1);
        i2c_stop();
        wq(20);
        check_val("sw_busy_out", 32'(busy), 32'h0);
        check_val("sw_we_cnt", 32'(wa_q.size()), 32'd1);
        check_val("sw_addr", wa_at(0), 32'h3008);
        check_val("sw_data", wd_at(0), 32'h82);

        // burst write
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'h30, 8'h0A, 8'h11, 8'h22, 5, acks);
        check_val("bw_acks", 32'(acks), 32'd5);
        check_val("bw_addr0", wa_at(0), 32'h300A);
        check_val("bw_data0", wd_at(0), 32'h11);
        check_val("bw_addr1", wa_at(1), 32'h300B);
        check_val("bw_data1", wd_at(1), 32'h22);
        check_val("bw_final_addr", 32'(rbus.reg_addr), 32'h300C);
        i2c_stop();

        // random read
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'h30, 8'h0A, 8'h00, 8'h00, 3, acks);
        i2c_start();
        send_byte(8'h79, 1'b0, a);
        if (a) acks++;
        check_val("rd_acks", 32'(acks), 32'd4);
        recv_byte(1'b0, r0);
        recv_byte(1'b1, r1);
        wq(20);
        check_val("rd_byte0", 32'(r0), 32'h50);
        check_val("rd_byte1", 32'(r1), 32'h51);
        check_val("rd_oe_after_nack", 32'(sda_oe), 32'h0);
        check_val("rd_re_cnt", 32'(re_cnt), 32'd2);
        check_val("rd_we_cnt", 32'(wa_q.size()), 32'd0);
        i2c_stop();
        wq(20);

        // address mismatch
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            i2c_start();
            send_byte(bad_addr[k], 1'b0, a);
            check_val("mm_ack", 32'(a), 32'h0);
            send_byte(8'h55, 1'b0, a);
            check_val("mm_ack2", 32'(a), 32'h0);
            i2c_stop();
            wq(20);
            check_val("mm_oe_seen", 32'(oe_seen), 32'h0);
            check_val("mm_we", 32'(wa_q.size()), 32'd0);
            check_val("mm_re", 32'(re_cnt), 32'd0);
            check_val("mm_busy", 32'(busy_seen), 32'h0);
        end

        // address wrap
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB, 5, acks);
        i2c_stop();
        wq(20);
        check_val("wr_acks", 32'(acks), 32'd5);
        check_val("wr_addr0", wa_at(0), 32'hFFFF);
        check_val("wr_data0", wd_at(0), 32'hAA);
        check_val("wr_addr1", wa_at(1), 32'h0000);
        check_val("wr_data1", wd_at(1), 32'hBB);

        // SDA glitch while SCL high must not register as START or STOP
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'h30, 8'h08, 8'h00, 8'h00, 3, acks);
        send_byte(8'hC3, 1'b1, a);
        check_val("gl_ack", 32'(a), 32'h1);
        check_val("gl_busy", 32'(busy), 32'h1);
        check_val("gl_we_cnt", 32'(wa_q.size()), 32'd1);
        check_val("gl_addr", wa_at(0), 32'h3008);
        check_val("gl_data", wd_at(0), 32'hC3);
        i2c_stop();
        wq(20);

        // reset mid-read while target drives SDA low
        i2c_start();
        write_seq(8'h78, 8'h30, 8'h0A, 8'h00, 8'h00, 3, acks);
        i2c_start();
        send_byte(8'h79, 1'b0, a);
        check_val("mr_oe_driving", 32'(sda_oe), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_oe_async", 32'(sda_oe), 32'h0);
        check_val("mr_addr", 32'(rbus.reg_addr), 32'h0);
        check_val("mr_wdata", 32'(rbus.reg_wdata), 32'h0);
        check_val("mr_we", 32'(rbus.reg_we), 32'h0);
        check_val("mr_re", 32'(rbus.reg_re), 32'h0);
        check_val("mr_busy", 32'(busy), 32'h0);
        scl = 1'b1;
        m_sda = 1'b1;
        wq(5);
        rst_n = 1'b1;
        wq(10);
        clear_mon();
        i2c_start();
        write_seq(8'h78, 8'h12, 8'h34, 8'h56, 8'h00, 4, acks);
        i2c_stop();
        wq(20);
        check_val("pr_acks", 32'(acks), 32'd4);
        check_val("pr_we_cnt", 32'(wa_q.size()), 32'd1);
        check_val("pr_addr", wa_at(0), 32'h1234);
        check_val("pr_data", wd_at(0), 32'h56);
        check_val("pr_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_target_regif.md
# i2c_target_regif

I2C target (slave) responder that exposes a simple register-bus interface. It answers an I2C master on the same two-wire bus, for example as a camera-register model for loopback and simulation of the sensor configuration path, or as a configuration port for on-chip registers. The block oversamples SCL and SDA on clk_i and detects START and STOP conditions. It matches a 7-bit device address and accepts a multi-byte register address followed by burst writes or burst reads with auto-increment.

## Interface
- DEV_ADDR, 7'h3C, 7-bit device address answered; 8-bit write/read bytes 0x78/0x79.
- ADDR_BYTES, 2, register address length in bytes (1 or 2), MSB first on the wire.
- FILT_LEN, 3, consecutive equal synchronized samples required before a filtered SCL/SDA level changes.

Ports:
- clk_i  in  1  system clock; must be ≥ 20× SCL frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- scl_i  in  1  raw SCL from pad (asynchronous).
- sda_i  in  1  raw SDA from pad (asynchronous).
- sda_oe  out  1  1 = pull SDA low; top level ties pad = sda_oe ? 1'b0 : 1'bz.
- reg_addr  out  8*ADDR_BYTES  current register address.
- reg_wdata  out  8  write data, valid while reg_we.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; must be valid on the clk_i cycle after reg_re.
- busy  out  1  high from address match until STOP, or until a START that does not re-match.

## Operation
- Input conditioning: each input passes a 2-flop synchronizer, then a FILT_LEN-sample glitch filter. Filtered edges produce single-cycle scl_rise, scl_fall, start, and stop events.
- START is filtered SDA falling while filtered SCL is high. STOP is filtered SDA rising while filtered SCL is high. Both are recognized in every state.
- SDA is sampled on scl_rise. sda_oe changes only on scl_fall, except on reset and STOP.
- States:
  - IDLE
  - DEVADDR
  - DEV_ACK
  - REGADDR
  - RA_ACK
  - WDATA
  - WD_ACK
  - RDATA
  - MACK (master ack)
  - IGNORE
- START from any state goes to DEVADDR and clears the bit counter. STOP from any state goes to IDLE, clears sda_oe and clears busy.
- DEVADDR:
  - After 8 bits, if byte[7:1]==DEV_ADDR, go to DEV_ACK: drive sda_oe=1 from the next scl_fall until the following scl_fall.
  - On mismatch (including general call 0x00), go to IGNORE with no ACK.
- Write path (R/W=0): receive ADDR_BYTES bytes into a staging register, ACKing each in RA_ACK. reg_addr commits only after the last address byte is ACKed; a partial address is discarded. Subsequent bytes go to WDATA/WD_ACK. Each byte pulses reg_we, is ACKed, then reg_addr increments.
- Read path (R/W=1), address retained from a prior write phase (random read via repeated START):
  - reg_re pulses on the scl_fall that ends the ACK; the shifter loads reg_rdata on the next cycle.
  - The block drives 8 bits MSB first: sda_oe = ~bit.
  - It releases SDA for the 9th clock and samples the master's ACK on scl_rise in MACK.
  - ACK (0): increment reg_addr, pulse reg_re, continue in RDATA. NACK (1): go to IGNORE with SDA released.
- IGNORE: sda_oe=0; wait for START or STOP.
- reg_addr increments modulo 2^(8*ADDR_BYTES); 16'hFFFF wraps to 16'h0000.

## Timing
- Reset values: sda_oe 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, busy 0, state IDLE. Asserting rst_n low mid-transfer releases SDA immediately, without waiting for a clock.
- Event latency from a raw pad edge to its filtered event: 2 + FILT_LEN clk_i cycles.
- sda_oe update: at most 2 clk_i cycles after scl_fall. First read bit: valid ≤ 3 cycles after scl_fall, leaving ample setup time at the 20× clock ratio.
- reg_we: asserts 1 cycle after scl_rise of the 8th data bit. reg_addr and reg_wdata are stable during reg_we; reg_addr increments on the cycle after reg_we.
- reg_re to reg_rdata capture: exactly 1 cycle.
- START during RDATA: SDA is released on the same cycle as the START event.

## Test plan
- Single write: START, 0x78, 0x30, 0x08, 0x82, STOP. Required: 4 ACKs; exactly one reg_we with reg_addr=0x3008 and reg_wdata=0x82; busy falls after STOP.
- Burst write: 0x78, 0x30, 0x0A, 0x11, 0x22. Required: reg_we at 0x300A/0x11, then at 0x300B/0x22; final reg_addr=0x300C.
- Random read, with a model returning addr[7:0]^0x5A: write 0x78, 0x30, 0x0A, then Sr, 0x79, read 2 bytes (master ACK, then NACK). Required: bytes 0x50, 0x51 on the wire; sda_oe=0 after the NACK.
- Address mismatch with 0x7A and with 0x00: no ACK; sda_oe=0 throughout; no reg_we/reg_re; busy stays 0.
- Wrap and glitch:
  - Write 0x78, 0xFF, 0xFF, 0xAA, 0xBB. Required: writes land at 0xFFFF and 0x0000.
  - Inject a 1-cycle SDA pulse while SCL is high. Required: no START/STOP detected.
- Reset mid-read while sda_oe=1. Required: sda_oe=0 asynchronously; all outputs at reset values; the next full write transaction completes correctly.
